// File: rtl/seq_mul.sv
// Purpose: sequential shift-and-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: done pulses WIDTH rising edges after the edge that samples start; Res is updated on that same edge.
// Backpressure: none; start is honoured in IDLE or DONE and ignored while busy (RUN).
//
// Ports:
//   clk        - clock, all state changes on its rising edge
//   reset      - asynchronous active-high reset
//   start      - request to begin a multiplication
//   A, B       - multiplicand / multiplier, WIDTH bits, latched on the accepting edge
//   sign_mode  - present only with MUL_SIGNED_EN defined; 1 = two's-complement operands
//   busy       - high exactly while the operation runs
//   done       - one-cycle completion pulse
//   Res        - registered 2*WIDTH-bit product, held until the next completed operation
//
// Configuration: define MUL_SIGNED_EN to add the sign_mode port and signed support
// (magnitudes are multiplied, the product is negated at completion if the signs differ).

module seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef MUL_SIGNED_EN
    input  logic                 sign_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Res
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last;
    logic [PW-1:0]    acc_sum;
    logic [PW-1:0]    product;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // A new operation can begin from IDLE or DONE; start during RUN is dropped.
    assign accept = start && (state != RUN);
    // cnt counts processed bits; the bit handled on this edge is the final one.
    assign last   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // Accumulator value including the multiplier bit processed on this edge.
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef MUL_SIGNED_EN
    logic neg;
    logic neg_nxt;

    // Magnitudes: negating the most negative value wraps to 2^(WIDTH-1), which
    // is the correct unsigned magnitude, so that operand needs no special case.
    assign a_mag   = (sign_mode && A[WIDTH-1]) ? -A : A;
    assign b_mag   = (sign_mode && B[WIDTH-1]) ? -B : B;
    assign neg_nxt = sign_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
    assign product = neg ? -acc_sum : acc_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= neg_nxt;
        end
    end
`else
    assign a_mag   = A;
    assign b_mag   = B;
    assign product = acc_sum;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: operand latch, shift-and-add, and result register. Res is only
    // written on the final RUN edge so partial sums never become visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            Res    <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                Res <= product;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
`ifdef MUL_SIGNED_EN
    logic           sign_mode;
`endif
    logic           busy;
    logic           done;
    logic [2*W-1:0] Res;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
`ifdef MUL_SIGNED_EN
        .sign_mode (sign_mode),
`endif
        .busy      (busy),
        .done      (done),
        .Res       (Res)
    );

    // Launch one operation (called #1 after a rising edge) and wait for done.
    // lat = rising edges from the start edge to the edge that raised done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output int lat,
                         output bit busy_ok, output bit res_held);
        logic [2*W-1:0] res_before;
        res_before = Res;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        res_held = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (Res !== res_before) res_held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = Res;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
`ifdef MUL_SIGNED_EN
        sign_mode = 1'b0;
`endif
        #2;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++;
        if (Res !== 32'h0) begin miscompares++; $display("FAIL reset_res got=%h exp=00000000", Res); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_unsigned_max();
        logic [2*W-1:0] r;
        int lat;
        bit bok, rh;
        do_op(16'hFFFF, 16'hFFFF, r, lat, bok, rh);
        vectors++;
        if (r !== 32'hFFFE0001) begin miscompares++; $display("FAIL max_res got=%h exp=fffe0001", r); end
        vectors++;
        if (lat !== 16) begin miscompares++; $display("FAIL max_latency got=%0d exp=16", lat); end
        vectors++;
        if (!bok) begin miscompares++; $display("FAIL max_busy_during_run got=0 exp=1"); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL max_busy_in_done got=%b exp=0", busy); end
        vectors++;
        if (!rh) begin miscompares++; $display("FAIL max_res_held_during_run got=changed exp=held"); end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL max_done_pulse_width got=%b exp=0", done); end
        vectors++;
        if (Res !== 32'hFFFE0001) begin miscompares++; $display("FAIL max_res_hold got=%h exp=fffe0001", Res); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] r;
        int lat;
        bit bok, rh;
        do_op(16'h1234, 16'h0000, r, lat, bok, rh);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL zero_res got=%h exp=00000000", r); end
        vectors++;
        if (lat !== 16) begin miscompares++; $display("FAIL zero_latency got=%0d exp=16", lat); end
        // Start issued in the done cycle: busy must be high on the very next cycle.
        do_op(16'h0003, 16'h0005, r, lat, bok, rh);
        vectors++;
        if (!bok) begin miscompares++; $display("FAIL b2b_no_idle got=idle_seen exp=busy"); end
        vectors++;
        if (lat !== 16) begin miscompares++; $display("FAIL b2b_latency got=%0d exp=16", lat); end
        vectors++;
        if (r !== 32'h0000000F) begin miscompares++; $display("FAIL b2b_res got=%h exp=0000000f", r); end
        vectors++;
        if (!rh) begin miscompares++; $display("FAIL b2b_res_held got=changed exp=held"); end
        @(posedge clk); #1;
    endtask

    task automatic test_patterns();
        logic [W-1:0]   ta [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h1234};
        logic [W-1:0]   tb [4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h5678};
        logic [2*W-1:0] te [4] = '{32'h0000FFFF, 32'h0000FFFF, 32'h40000000, 32'h06260060};
        logic [2*W-1:0] r;
        int lat;
        bit bok, rh;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], r, lat, bok, rh);
            vectors++;
            if (r !== te[i] || lat !== 16) begin
                miscompares++;
                $display("FAIL pattern_%0d got=%h/lat%0d exp=%h/lat16", i, r, lat, te[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int n;
        A = 16'd7;
        B = 16'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (n == 4) begin
                start = 1'b1;
                A = 16'd2;
                B = 16'd2;
            end else begin
                start = 1'b0;
                A = W'($urandom);
                B = W'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        vectors++;
        if (n !== 16) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=16", n); end
        vectors++;
        if (Res !== 32'h0000003F) begin miscompares++; $display("FAIL ignore_res got=%h exp=0000003f", Res); end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_return_idle got=done%b/busy%b exp=0/0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [2*W-1:0] r;
        int lat, pulses;
        bit bok, rh;
        A = 16'h00FF;
        B = 16'h0101;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || Res !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_async got=busy%b/done%b/%h exp=0/0/00000000", busy, done, Res);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        vectors++;
        if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_done got=%0d active cycles exp=0", pulses); end
        do_op(16'h00FF, 16'h0101, r, lat, bok, rh);
        vectors++;
        if (r !== 32'h0000FFFF || lat !== 16) begin
            miscompares++;
            $display("FAIL after_reset got=%h/lat%0d exp=0000ffff/lat16", r, lat);
        end
        @(posedge clk); #1;
    endtask

`ifdef MUL_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0]   sa [4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h0003};
        logic [W-1:0]   sb [4] = '{16'hFFFF, 16'h8000, 16'h0001, 16'hFFFB};
        logic [2*W-1:0] se [4] = '{32'h00000001, 32'h40000000, 32'hFFFF8000, 32'hFFFFFFF1};
        logic [2*W-1:0] r;
        int lat;
        bit bok, rh;
        sign_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(sa[i], sb[i], r, lat, bok, rh);
            vectors++;
            if (r !== se[i] || lat !== 16) begin
                miscompares++;
                $display("FAIL signed_%0d got=%h/lat%0d exp=%h/lat16", i, r, lat, se[i]);
            end
            @(posedge clk); #1;
        end
        sign_mode = 1'b0;
        do_op(16'h8000, 16'h0001, r, lat, bok, rh);
        vectors++;
        if (r !== 32'h00008000) begin miscompares++; $display("FAIL unsigned_mode_8000 got=%h exp=00008000", r); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_back_to_back();
        test_patterns();
        test_ignore_start();
        test_reset_abort();
`ifdef MUL_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 The block SHALL expose the parameter WIDTH, default 16, as operand width in bits; the legal range is 2..64.
REQ-002 The block SHALL expose port clk, input, 1 bit, as the single clock; all state changes on its rising edge.
REQ-003 The block SHALL expose port reset, input, 1 bit, as an asynchronous, active-high reset.
REQ-004 The block SHALL expose port start, input, 1 bit, as the request to begin a multiplication.
REQ-005 The block SHALL expose port A, input, WIDTH bits, as the multiplicand.
REQ-006 The block SHALL expose port B, input, WIDTH bits, as the multiplier.
REQ-007 The block SHALL expose port sign_mode, input, 1 bit, only when MUL_SIGNED_EN is defined; 1 means two's-complement operands.
REQ-008 The block SHALL expose port busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL expose port done, output, 1 bit, as a one-cycle completion pulse.
REQ-010 The block SHALL expose port Res, output, 2*WIDTH bits, as the registered product.

Function
REQ-011 The block SHALL use a state machine with three states: IDLE, RUN and DONE.
REQ-012 start sampled high in IDLE or DONE SHALL latch A, B (and sign_mode), clear the accumulator and counter, and enter RUN.
REQ-013 start in RUN SHALL be ignored: operands are not re-latched and the operation is not restarted.
REQ-014 RUN SHALL process exactly one multiplier bit per cycle, LSB first, as shift-and-add: if the bit is 1, add the shifted multiplicand into the 2*WIDTH accumulator, then shift the multiplicand left by 1.
REQ-015 A WIDTH-bit-capable counter SHALL leave RUN on the WIDTH-th rising edge after the edge that sampled start, going to DONE.
REQ-016 On entry to DONE, Res SHALL load the final product and done SHALL be 1 for exactly one cycle.
REQ-017 Res SHALL hold its value until the next completed operation; intermediate accumulator values SHALL never appear on Res.
REQ-018 busy SHALL be 1 exactly while in RUN.
REQ-019 DONE SHALL return to IDLE after one cycle when start is low; start high in DONE SHALL enter RUN directly, giving back-to-back operation with no idle cycle.
REQ-020 The unsigned product SHALL be exact modulo 2^(2*WIDTH); no overflow is possible.
REQ-021 Operand changes on A or B after the start edge SHALL NOT affect the result.

Reset
REQ-022 While reset is high, the state SHALL be IDLE, and busy, done, Res, the accumulator, the latched operands and the counter SHALL be 0, independent of clk.
REQ-023 Reset asserted in RUN SHALL abort the operation with no done pulse; Res SHALL read 0.
REQ-024 After reset deasserts, the first start sampled on a rising edge SHALL be accepted normally.

Configuration
REQ-025 Macro MUL_SIGNED_EN defined: the sign_mode port exists.
- sign_mode=1 at start: absolute values of A and B are latched; the magnitude product is computed as in REQ-014; at DONE the result is two's-complement negated if the operand signs differ.
- -2^(WIDTH-1) operands SHALL be handled exactly.
- Latency SHALL be identical to unsigned mode.
REQ-026 Macro MUL_SIGNED_EN undefined: no sign_mode port and no sign or negation logic; operation is unsigned only.

Verification (WIDTH=16)
REQ-027 A=0xFFFF, B=0xFFFF, start for 1 cycle -> busy for 16 cycles, done pulse on the 16th edge, Res=0xFFFE0001, busy=0 in the done cycle.
REQ-028 A=0x1234, B=0 -> Res=0x00000000 with the same 16-cycle latency; then A=0x0003, B=0x0005 with start in the done cycle -> no IDLE cycle, Res=0x0000000F.
REQ-029 A=7, B=9 started; start re-pulsed with A=2, B=2 in RUN cycle 5 -> ignored, Res=0x0000003F at done; A/B toggled during RUN -> no effect.
REQ-030 Reset asserted in RUN cycle 8 -> busy, done and Res immediately 0, no done pulse; start after release -> correct result.
REQ-031 MUL_SIGNED_EN, sign_mode=1:
- 0xFFFF*0xFFFF -> 0x00000001
- 0x8000*0x8000 -> 0x40000000
- 0x8000*0x0001 -> 0xFFFF8000
- sign_mode=0, 0x8000*0x0001 -> 0x00008000
